renode_apb4_requester_queued: RTL

// - Queued, parametrised APB4 requester: bus-side master between a valid/ready request port and an APB4 completer.
// - Buffers up to QueueDepth requests; issues back-to-back transfers without returning to IDLE; adds PSTRB/PPROT.
// - One response pulse per transfer. Optional wait-state timeout.

---
 rtl/renode_apb4_requester_queued_if.sv | 48 ++++
 rtl/renode_apb4_requester_queued.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/renode_apb4_requester_queued_if.sv
// Bus bundle for the queued APB4 requester: request port, response port and
// the APB4 completer signals. The master modport is the requester's view; the
// slave modport is the view of the surrounding system (request source plus
// APB completer).
interface renode_apb4_requester_queued_if #(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32
);
  localparam int StrbWidth = DataWidth / 8;

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [AddressWidth-1:0] req_addr;
  logic [DataWidth-1:0]    req_wdata;
  logic [StrbWidth-1:0]    req_strb;
  logic [2:0]              req_prot;

  logic                    rsp_valid;
  logic [DataWidth-1:0]    rsp_rdata;
  logic                    rsp_error;
  logic                    rsp_timeout;

  logic [AddressWidth-1:0] paddr;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DataWidth-1:0]    pwdata;
  logic [StrbWidth-1:0]    pstrb;
  logic [2:0]              pprot;
  logic                    pready;
  logic [DataWidth-1:0]    prdata;
  logic                    pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    input  pready, prdata, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
    output paddr, psel, penable, pwrite, pwdata, pstrb, pprot
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    output pready, prdata, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
    input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot
  );
endinterface

// File: rtl/renode_apb4_requester_queued.sv
// Queued APB4 requester. Requests are buffered in a small FIFO and issued as
// back-to-back APB transfers, with a forced IDLE cycle after Back2BackNum
// consecutive transfers. One rsp_valid pulse per completed transfer.
// Optional wait-state timeout: define RENODE_APB4_REQ_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no transfer on the bus; pops the FIFO head when level != 0
// SETUP  | psel = 1, penable = 0; always advances to ACCESS
// ACCESS | psel = 1, penable = 1; waits for pready (or timeout abort)
module renode_apb4_requester_queued #(
  parameter int AddressWidth  = 32,
  parameter int DataWidth     = 32,
  parameter int QueueDepth    = 4,
  parameter int Back2BackNum  = 4,
  parameter int TimeoutCycles = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  renode_apb4_requester_queued_if.master   bus,
  output logic                             busy,
  output logic [$clog2(QueueDepth+1)-1:0]  queue_level
);
  localparam int StrbWidth  = DataWidth / 8;
  localparam int LevelWidth = $clog2(QueueDepth + 1);
  localparam int PtrWidth   = $clog2(QueueDepth);
  localparam int RunWidth   = $clog2(Back2BackNum + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  typedef struct packed {
    logic                    write;
    logic [AddressWidth-1:0] addr;
    logic [DataWidth-1:0]    wdata;
    logic [StrbWidth-1:0]    strb;
    logic [2:0]              prot;
  } xfer_t;

  state_t                state;
  xfer_t                 fifo_mem [QueueDepth];
  xfer_t                 in_req;
  xfer_t                 head_req;
  xfer_t                 xfer;
  logic [PtrWidth-1:0]   wr_ptr;
  logic [PtrWidth-1:0]   rd_ptr;
  logic [LevelWidth-1:0] level;
  logic [RunWidth-1:0]   run_cnt;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  chain;
  logic                  abort;
  logic                  psel_q;
  logic                  penable_q;
  logic                  rsp_valid_q;
  logic                  rsp_error_q;
  logic [DataWidth-1:0]  rsp_rdata_q;

  // Read requests carry zero data/strobes so the APB outputs need no gating later.
  always_comb begin
    in_req       = '0;
    in_req.write = bus.req_write;
    in_req.addr  = bus.req_addr;
    in_req.wdata = bus.req_write ? bus.req_wdata : '0;
    in_req.strb  = bus.req_write ? bus.req_strb : '0;
    in_req.prot  = bus.req_prot;
  end

  // Full is judged on the registered level, so a same-cycle pop never frees a slot.
  assign full     = (level == LevelWidth'(QueueDepth));
  assign push     = bus.req_valid && !full;
  assign head_req = fifo_mem[rd_ptr];
  assign chain    = (level != '0) && (run_cnt < RunWidth'(Back2BackNum));
  assign pop      = ((state == IDLE) && (level != '0)) ||
                    ((state == ACCESS) && bus.pready && chain);

  // FIFO storage; entries need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_req;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

`ifdef RENODE_APB4_REQ_TIMEOUT_EN
  localparam int WaitWidth = $clog2(TimeoutCycles + 1);
  logic [WaitWidth-1:0] wait_cnt;
  logic                 rsp_timeout_q;

  // Terminal count reached on the last allowed stalled ACCESS cycle.
  assign abort = (state == ACCESS) && !bus.pready && (wait_cnt == '0);

  // Wait timer: reloads in SETUP, counts down through stalled ACCESS cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt      <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_timeout_q <= abort;
      if (state == SETUP)
        wait_cnt <= WaitWidth'(TimeoutCycles - 1);
      else if ((state == ACCESS) && !bus.pready && (wait_cnt != '0))
        wait_cnt <= wait_cnt - 1'b1;
    end
  end

  assign bus.rsp_timeout = rsp_timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TimeoutCycles != 0);
  assign abort              = 1'b0;
  assign bus.rsp_timeout    = 1'b0;
`endif

  // Transfer sequencer with registered APB controls and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      run_cnt     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      xfer        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      case (state)
        IDLE: begin
          if (level != '0) begin
            state     <= SETUP;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            xfer      <= head_req;
            run_cnt   <= RunWidth'(1);
          end
        end
        SETUP: begin
          state     <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (bus.pready) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= xfer.write ? '0 : bus.prdata;
            rsp_error_q <= bus.pslverr;
            if (chain) begin
              state     <= SETUP;
              penable_q <= 1'b0;
              xfer      <= head_req;
              run_cnt   <= run_cnt + 1'b1;
            end else begin
              state     <= IDLE;
              psel_q    <= 1'b0;
              penable_q <= 1'b0;
              xfer      <= '0;
            end
          end else if (abort) begin
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b1;
            state       <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            xfer        <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          xfer      <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready = !full;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.paddr     = xfer.addr;
  assign bus.pwrite    = xfer.write;
  assign bus.pwdata    = xfer.wdata;
  assign bus.pstrb     = xfer.strb;
  assign bus.pprot     = xfer.prot;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;
  assign busy          = (state != IDLE) || (level != '0);
  assign queue_level   = level;
endmodule
